// File: rtl/pwm_demod_pkg.sv
// Audio-path constants shared between the music PWM generator and its receive-side demodulator.
package pwm_demod_pkg;

  localparam int unsigned INPUT_FREQUENCY = 25_000_000;
  localparam int unsigned FRAME_BITS      = 7;
  localparam int unsigned SAMPLE_RATE     = INPUT_FREQUENCY >> FRAME_BITS;

  typedef logic [0:0] state_t;

  localparam state_t HUNT   = 1'b0;
  localparam state_t LOCKED = 1'b1;

endpackage

// File: rtl/pwm_demod_if.sv
// PWM stream in, recovered samples and status out; master drives the stream, slave demodulates.
interface pwm_demod_if #(
  parameter int unsigned FRAME_BITS = 7
) ();

  logic                  pwm_in;
  logic [FRAME_BITS-1:0] sample;
  logic                  sample_valid;
  logic                  gate;
  logic                  note_start;
  logic                  sync_err;
  logic                  locked;

  modport master (
    output pwm_in,
    input  sample, sample_valid, gate, note_start, sync_err, locked
  );

  modport slave (
    input  pwm_in,
    output sample, sample_valid, gate, note_start, sync_err, locked
  );

endinterface

// File: rtl/pwm_demod_sync_ff.sv
// Multi-flop synchronizer for an asynchronous input, with a registered-edge rising detector.
module pwm_demod_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      dly_q  <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = q_o & ~dly_q;

endmodule

// File: rtl/pwm_demod.sv
// Recovers one sample per 128-clock PWM frame by counting high cycles after locking to frame starts.
module pwm_demod #(
  parameter int unsigned FRAME_BITS       = 7,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned LOCK_LOSS_FRAMES = 4
) (
  input logic        clk,
  input logic        rst_n,
  pwm_demod_if.slave bus
);

  import pwm_demod_pkg::*;

  localparam int unsigned EmptyW = $clog2(LOCK_LOSS_FRAMES + 1);
  localparam logic [FRAME_BITS-1:0] PosLast  = '1;
  localparam logic [EmptyW-1:0]     EmptyMax = EmptyW'(LOCK_LOSS_FRAMES);

  logic s, rise;

  pwm_demod_sync_ff #(
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.pwm_in),
    .q_o    (s),
    .rise_o (rise)
  );

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] pos_q, pos_d;
  logic [FRAME_BITS:0]   high_q, high_d;
  logic [EmptyW-1:0]     empty_q, empty_d;
  logic [FRAME_BITS-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  gate_q, gate_d;
  logic                  note_q, note_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;

  logic [FRAME_BITS:0] total;
  logic [EmptyW-1:0]   empty_inc;

  // total includes the final position's bit, which has not been accumulated yet
  assign total     = high_q + (FRAME_BITS+1)'(s);
  assign empty_inc = empty_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    high_d   = high_q;
    empty_d  = empty_q;
    sample_d = sample_q;
    gate_d   = gate_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    note_d   = 1'b0;
    err_d    = 1'b0;

    if (state_q == HUNT) begin
      if (rise) begin
        pos_d    = FRAME_BITS'(1);
        high_d   = (FRAME_BITS+1)'(1);
        state_d  = LOCKED;
        locked_d = 1'b1;
      end
    end else if (rise && (pos_q != '0)) begin
      // Misaligned edge: realign on it and drop the partial frame
      err_d  = 1'b1;
      pos_d  = FRAME_BITS'(1);
      high_d = (FRAME_BITS+1)'(1);
    end else begin
      pos_d  = pos_q + 1'b1;
      high_d = (pos_q == '0) ? (FRAME_BITS+1)'(s) : total;
      if (pos_q == PosLast) begin
        if (total != '0) begin
          sample_d = FRAME_BITS'(total - 1'b1);
          valid_d  = 1'b1;
          note_d   = ~gate_q;
          gate_d   = 1'b1;
          empty_d  = '0;
        end else begin
          gate_d = 1'b0;
          if (empty_inc == EmptyMax) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            empty_d  = '0;
          end else begin
            empty_d = empty_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      high_q   <= '0;
      empty_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      gate_q   <= 1'b0;
      note_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      high_q   <= high_d;
      empty_q  <= empty_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      gate_q   <= gate_d;
      note_q   <= note_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.gate         = gate_q;
  assign bus.note_start   = note_q;
  assign bus.sync_err     = err_q;
  assign bus.locked       = locked_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed scenarios for pwm_demod; strobes are logged with their cycle number and checked per task.
module tb_pwm_demod;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int v_cyc[$];
  int v_smp[$];
  int n_cyc[$];
  int e_cyc[$];

  pwm_demod_if #(.FRAME_BITS(7)) bus ();

  pwm_demod #(
    .FRAME_BITS       (7),
    .SYNC_STAGES      (2),
    .LOCK_LOSS_FRAMES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sample_valid) begin
      v_cyc.push_back(cyc);
      v_smp.push_back(int'(bus.sample));
    end
    if (bus.note_start) n_cyc.push_back(cyc);
    if (bus.sync_err) e_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    v_cyc.delete();
    v_smp.delete();
    n_cyc.delete();
    e_cyc.delete();
  endtask

  // Value p is sampled at the next edge; cyc then holds that edge's number
  task automatic drive(input logic p);
    bus.pwm_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int highs, output int start);
    start = 0;
    for (int i = 0; i < 128; i++) begin
      drive(i < highs);
      if (i == 0) start = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1);
    n_checks++; if (bus.sample !== 7'd0) begin n_errors++; $display("FAIL reset_sample: got %0d want 0", bus.sample); end
    n_checks++; if (bus.sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", bus.sample_valid); end
    n_checks++; if (bus.gate !== 1'b0) begin n_errors++; $display("FAIL reset_gate: got %0b want 0", bus.gate); end
    n_checks++; if (bus.note_start !== 1'b0) begin n_errors++; $display("FAIL reset_note: got %0b want 0", bus.note_start); end
    n_checks++; if (bus.sync_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b want 0", bus.sync_err); end
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0);
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL idle_locked: got %0b want 0", bus.locked); end
  endtask

  task automatic test_first_frame();
    int e, d;
    clear_logs();
    send_frame(1, e);
    n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL first_locked: got %0b want 1", bus.locked); end
    send_frame(0, d);
    n_checks++; if (v_cyc.size() != 1) begin n_errors++; $display("FAIL first_nvalid: got %0d want 1", v_cyc.size()); end
    n_checks++; if (((v_cyc.size() > 0) ? v_cyc[0] : -1) != e + 129) begin n_errors++; $display("FAIL first_valid_cyc: got %0d want %0d", (v_cyc.size() > 0) ? v_cyc[0] : -1, e + 129); end
    n_checks++; if (((v_smp.size() > 0) ? v_smp[0] : -1) != 0) begin n_errors++; $display("FAIL first_sample: got %0d want 0", (v_smp.size() > 0) ? v_smp[0] : -1); end
    n_checks++; if (((n_cyc.size() == 1) ? n_cyc[0] : -1) != e + 129) begin n_errors++; $display("FAIL first_note: got %0d want %0d", (n_cyc.size() == 1) ? n_cyc[0] : -1, e + 129); end
    n_checks++; if (bus.gate !== 1'b1) begin n_errors++; $display("FAIL first_gate: got %0b want 1", bus.gate); end
  endtask

  task automatic test_back_to_back();
    int e, d;
    int exp_s[3];
    exp_s = '{64, 127, 0};
    clear_logs();
    send_frame(65, e);
    send_frame(128, d);
    send_frame(1, d);
    send_frame(1, d);
    n_checks++; if (v_cyc.size() != 3) begin n_errors++; $display("FAIL b2b_nvalid: got %0d want 3", v_cyc.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < v_cyc.size()) begin
        n_checks++; if (v_cyc[k] != e + 129 + 128 * k) begin n_errors++; $display("FAIL b2b_cyc%0d: got %0d want %0d", k, v_cyc[k], e + 129 + 128 * k); end
        n_checks++; if (v_smp[k] != exp_s[k]) begin n_errors++; $display("FAIL b2b_smp%0d: got %0d want %0d", k, v_smp[k], exp_s[k]); end
      end
    end
    n_checks++; if (((n_cyc.size() == 1) ? n_cyc[0] : -1) != e + 129) begin n_errors++; $display("FAIL b2b_note: got %0d notes want one at %0d", n_cyc.size(), e + 129); end
    n_checks++; if (e_cyc.size() != 0) begin n_errors++; $display("FAIL b2b_err: got %0d want 0", e_cyc.size()); end
  endtask

  task automatic test_lock_loss();
    int e, d;
    clear_logs();
    send_frame(0, e);
    n_checks++; if (bus.gate !== 1'b1) begin n_errors++; $display("FAIL loss_gate_held: got %0b want 1", bus.gate); end
    send_frame(0, d);
    n_checks++; if (bus.gate !== 1'b0) begin n_errors++; $display("FAIL loss_gate_fall: got %0b want 0", bus.gate); end
    send_frame(0, d);
    send_frame(0, d);
    n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL loss_locked_held: got %0b want 1", bus.locked); end
    drive(1'b0);
    drive(1'b0);
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL loss_unlocked: got %0b want 0", bus.locked); end
    // Only the strobe of the last playing frame lands here, at position 1 of the first empty frame
    n_checks++; if (((v_cyc.size() == 1) ? v_cyc[0] : -1) != e + 1) begin n_errors++; $display("FAIL loss_nvalid: got %0d strobes want one at %0d", v_cyc.size(), e + 1); end
  endtask

  task automatic test_relock();
    int e, d;
    clear_logs();
    for (int i = 0; i < 3; i++) drive(1'b0);
    send_frame(10, e);
    n_checks++; if (bus.locked !== 1'b1) begin n_errors++; $display("FAIL relock_locked: got %0b want 1", bus.locked); end
    send_frame(10, d);
    n_checks++; if (((v_cyc.size() == 1) ? v_cyc[0] : -1) != e + 129) begin n_errors++; $display("FAIL relock_valid: got %0d strobes want one at %0d", v_cyc.size(), e + 129); end
    n_checks++; if (((v_smp.size() > 0) ? v_smp[0] : -1) != 9) begin n_errors++; $display("FAIL relock_sample: got %0d want 9", (v_smp.size() > 0) ? v_smp[0] : -1); end
    n_checks++; if (n_cyc.size() != 1) begin n_errors++; $display("FAIL relock_note: got %0d want 1", n_cyc.size()); end
  endtask

  task automatic test_sync_err();
    int ef, einj, d;
    ef = 0;
    einj = 0;
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      drive(i < 10);
      if (i == 0) ef = cyc;
    end
    for (int i = 0; i < 128; i++) begin
      drive(i < 5);
      if (i == 0) einj = cyc;
    end
    send_frame(10, d);
    n_checks++; if (((e_cyc.size() == 1) ? e_cyc[0] : -1) != einj + 2) begin n_errors++; $display("FAIL serr_pulse: got %0d pulses want one at %0d", e_cyc.size(), einj + 2); end
    n_checks++; if (v_cyc.size() != 2) begin n_errors++; $display("FAIL serr_nvalid: got %0d want 2", v_cyc.size()); end
    n_checks++; if (((v_cyc.size() > 0) ? v_cyc[0] : -1) != ef + 1) begin n_errors++; $display("FAIL serr_prev_cyc: got %0d want %0d", (v_cyc.size() > 0) ? v_cyc[0] : -1, ef + 1); end
    n_checks++; if (((v_cyc.size() > 1) ? v_cyc[1] : -1) != einj + 129) begin n_errors++; $display("FAIL serr_next_cyc: got %0d want %0d", (v_cyc.size() > 1) ? v_cyc[1] : -1, einj + 129); end
    n_checks++; if (((v_smp.size() > 1) ? v_smp[1] : -1) != 4) begin n_errors++; $display("FAIL serr_next_smp: got %0d want 4", (v_smp.size() > 1) ? v_smp[1] : -1); end
    n_checks++; if (n_cyc.size() != 0) begin n_errors++; $display("FAIL serr_note: got %0d want 0", n_cyc.size()); end
  endtask

  task automatic test_loopback();
    localparam int N = 16;
    int smp[N];
    int lb, st, d;
    lb = 0;
    for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(0, 127));
    smp[0] = 127;
    smp[1] = 127;
    smp[2] = 0;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      send_frame(smp[i] + 1, st);
      if (i == 0) lb = st;
    end
    send_frame(1, d);
    n_checks++; if (v_cyc.size() != N + 1) begin n_errors++; $display("FAIL loop_nvalid: got %0d want %0d", v_cyc.size(), N + 1); end
    for (int i = 0; i < N; i++) begin
      if (i + 1 < v_cyc.size()) begin
        n_checks++; if (v_smp[i+1] != smp[i]) begin n_errors++; $display("FAIL loop_smp%0d: got %0d want %0d", i, v_smp[i+1], smp[i]); end
        n_checks++; if (v_cyc[i+1] != lb + 129 + 128 * i) begin n_errors++; $display("FAIL loop_cyc%0d: got %0d want %0d", i, v_cyc[i+1], lb + 129 + 128 * i); end
      end
    end
    n_checks++; if (e_cyc.size() != 0) begin n_errors++; $display("FAIL loop_err: got %0d want 0", e_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int en, d;
    clear_logs();
    for (int i = 0; i < 60; i++) drive(i < 10);
    rst_n = 1'b0;
    drive(1'b0);
    rst_n = 1'b1;
    n_checks++; if (bus.sample !== 7'd0) begin n_errors++; $display("FAIL mid_sample: got %0d want 0", bus.sample); end
    n_checks++; if (bus.gate !== 1'b0) begin n_errors++; $display("FAIL mid_gate: got %0b want 0", bus.gate); end
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL mid_locked: got %0b want 0", bus.locked); end
    n_checks++; if ({bus.sample_valid, bus.note_start, bus.sync_err} !== 3'b000) begin n_errors++; $display("FAIL mid_strobes: got %03b want 000", {bus.sample_valid, bus.note_start, bus.sync_err}); end
    for (int i = 0; i < 100; i++) drive(1'b0);
    n_checks++; if (v_cyc.size() != 1) begin n_errors++; $display("FAIL mid_no_strobe: got %0d want 1", v_cyc.size()); end
    n_checks++; if (bus.locked !== 1'b0) begin n_errors++; $display("FAIL mid_hunt: got %0b want 0", bus.locked); end
    send_frame(20, en);
    for (int i = 0; i < 3; i++) drive(1'b0);
    n_checks++; if (((v_cyc.size() == 2) ? v_cyc[1] : -1) != en + 129) begin n_errors++; $display("FAIL mid_relock_cyc: got %0d strobes want 2nd at %0d", v_cyc.size(), en + 129); end
    n_checks++; if (((v_smp.size() == 2) ? v_smp[1] : -1) != 19) begin n_errors++; $display("FAIL mid_relock_smp: got %0d want 19", (v_smp.size() == 2) ? v_smp[1] : -1); end
    n_checks++; if (((n_cyc.size() == 1) ? n_cyc[0] : -1) != en + 129) begin n_errors++; $display("FAIL mid_relock_note: got %0d notes want one at %0d", n_cyc.size(), en + 129); end
    d = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_lock_loss();
    test_relock();
    test_sync_err();
    test_loopback();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
